n_bit_adder_flags: RTL and testbench
====================================

// Module: n_bit_adder_flags
// PURPOSE
//  Registered N-bit two's-complement/unsigned adder producing sum R = A + B and
//  four status flags {N,Z,C,V}. ALU-style datapath leaf used by the lab datapath.
//  Inputs sampled each clock; result and flags held in registers until next update.
// PARAMETERS
//  N   default 4   operand/result width in bits (N >= 2)
// PORTS
//  clk      in   1    system clock, rising-edge active
//  rst_n    in   1    asynchronous reset, active low
//  in_valid in   1    operands on a/b valid this cycle; capture on clk rise
//  a        in   N    operand A
//  b        in   N    operand B
//  r        out  N    registered sum A+B (mod 2^N)
//  f        out  4    registered flags {N,Z,C,V} = f[3:0]
//  out_valid out 1    high one cycle after an accepted in_valid
// BEHAVIOUR
//  - One clock, one async active-low reset. Reset: r=0, f=4'b0000, out_valid=0,
//    applied immediately on rst_n falling, regardless of clk; released synchronously
//    in effect (first capture on first clk rise with rst_n=1).
//  - Datapath: ripple-carry chain of N full adders (generate loop), carry-in 0.
//    sum[i]=a[i]^b[i]^c[i]; c[i+1]=a[i]&b[i] | c[i]&(a[i]^b[i]).
//  - Flags, computed combinationally from the same operands, registered with sum:
//    f[3] N = sum[N-1]
//    f[2] Z = (sum == 0)
//    f[1] C = c[N] (unsigned carry out)
//    f[0] V = c[N] ^ c[N-1] (signed overflow)
//  - Latency 1 cycle: on clk rise with in_valid=1, r/f load from a/b; out_valid=1
//    in the following cycle. in_valid=0: r/f hold, out_valid=0.
//  - Back-to-back in_valid accepted every cycle; no backpressure, no stall.
//  - Reset asserted mid-operation discards the in-flight result (r,f,out_valid -> 0).
//  - Wrap-around: sum truncated to N bits; carry reported only via C.
//  - No X propagation on outputs after reset; all outputs driven from flops.
// TESTING
//  - Reset: rst_n=0 asynchronously between edges -> r=0, f=0000, out_valid=0 at once.
//  - a=1001,b=0101,in_valid=1 -> next cycle r=1110, f=1000 (N), out_valid=1.
//  - a=1111,b=0001 -> r=0000, f=0110 (Z,C), unsigned wrap.
//  - a=0001,b=0001 -> r=0010, f=0000; then in_valid=0 -> r/f hold, out_valid=0.
//  - a=0111,b=0001 -> r=1000, f=1001 (N,V); a=1000,b=1000 -> r=0000, f=0111 (Z,C,V).
//  - Back-to-back 3 operand pairs on consecutive cycles -> 3 consecutive correct
//    results; exhaustive N=4 sweep vs reference model A+B with flags as above.

Source files
------------

// File: rtl/n_bit_adder_flags.sv
// Registered N-bit ripple-carry adder with {N,Z,C,V} status flags.
// Operands are captured on an in_valid clock edge, and the result is valid one cycle later.
module n_bit_adder_flags #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] r,
    output logic [3:0]   f,
    output logic         out_valid
);

    logic [N:0]   carry;
    logic [N-1:0] sum_next;
    logic [3:0]   flags_next;

    logic [N-1:0] r_reg;
    logic [3:0]   f_reg;
    logic         out_valid_reg;

    assign carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_full_adder
            assign sum_next[gi]  = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1]   = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    // Signed overflow occurs when the carry into the MSB differs from the carry out of it.
    always_comb begin
        flags_next    = 4'b0000;
        flags_next[3] = sum_next[N-1];
        flags_next[2] = (sum_next == '0);
        flags_next[1] = carry[N];
        flags_next[0] = carry[N] ^ carry[N-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg         <= '0;
            f_reg         <= 4'b0000;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                r_reg <= sum_next;
                f_reg <= flags_next;
            end
        end
    end

    assign r         = r_reg;
    assign f         = f_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_n_bit_adder_flags.sv
// Self-checking bench for n_bit_adder_flags: directed vectors, a reset sequence,
// an exhaustive N=4 sweep, and randomized traffic checked against an arithmetic model.
module tb_n_bit_adder_flags;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] r;
    logic [3:0]   f;
    logic         out_valid;

    int total = 0;
    int bad   = 0;

    logic [N-1:0] exp_r;
    logic [3:0]   exp_f;
    logic         exp_v;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] r;
        logic [3:0]   f;
    } vec_t;

    vec_t vecs [5];

    n_bit_adder_flags #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .r         (r),
        .f         (f),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, unsigned and signed interpretations.
    function automatic logic [N+3:0] model(input logic [N-1:0] x, input logic [N-1:0] y);
        int unsigned  us;
        int           sx, sy, ss;
        logic [N-1:0] res;
        logic [3:0]   fl;
        us  = int'(x) + int'(y);
        res = N'(us % (1 << N));
        sx  = (int'(x) >= (1 << (N-1))) ? int'(x) - (1 << N) : int'(x);
        sy  = (int'(y) >= (1 << (N-1))) ? int'(y) - (1 << N) : int'(y);
        ss  = sx + sy;
        fl[3] = (int'(res) >= (1 << (N-1)));
        fl[2] = (res == '0);
        fl[1] = (us >= (1 << N));
        fl[0] = (ss > (1 << (N-1)) - 1) || (ss < -(1 << (N-1)));
        return {fl, res};
    endfunction

    task automatic check(input string name);
        total++;
        if (r !== exp_r || f !== exp_f || out_valid !== exp_v) begin
            bad++;
            $display("FAIL %s: got r=%b f=%b v=%b, want r=%b f=%b v=%b",
                     name, r, f, out_valid, exp_r, exp_f, exp_v);
        end else begin
            $display("ok   %s: r=%b f=%b v=%b", name, r, f, out_valid);
        end
    endtask

    // At each falling edge: check the result of the previous cycle, then drive the next.
    task automatic step(input string name, input logic v, input logic [N-1:0] ai,
                        input logic [N-1:0] bi, input logic [N-1:0] er, input logic [3:0] ef);
        @(negedge clk);
        check(name);
        in_valid = v;
        a        = ai;
        b        = bi;
        if (v) begin
            exp_r = er;
            exp_f = ef;
            exp_v = 1'b1;
        end else begin
            exp_v = 1'b0;
        end
    endtask

    task automatic step_model(input string name, input logic v, input logic [N-1:0] ai,
                              input logic [N-1:0] bi);
        logic [N+3:0] m;
        m = model(ai, bi);
        step(name, v, ai, bi, m[N-1:0], m[N+3:N]);
    endtask

    initial begin
        vecs[0] = '{a: 4'b1001, b: 4'b0101, r: 4'b1110, f: 4'b1000};
        vecs[1] = '{a: 4'b1111, b: 4'b0001, r: 4'b0000, f: 4'b0110};
        vecs[2] = '{a: 4'b0111, b: 4'b0001, r: 4'b1000, f: 4'b1001};
        vecs[3] = '{a: 4'b1000, b: 4'b1000, r: 4'b0000, f: 4'b0111};
        vecs[4] = '{a: 4'b0001, b: 4'b0001, r: 4'b0010, f: 4'b0000};

        rst_n    = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        exp_r    = '0;
        exp_f    = 4'b0000;
        exp_v    = 1'b0;

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1 check("reset_async");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table, applied back-to-back, followed by an idle cycle (hold).
        for (int i = 0; i < 5; i++)
            step($sformatf("vec%0d_issue", i), 1'b1, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].f);
        step("vec4_result", 1'b0, 4'b1010, 4'b1010, '0, '0);
        step("hold_idle", 1'b0, 4'b0011, 4'b0100, '0, '0);
        step("hold_idle2", 1'b0, '0, '0, '0, '0);

        // Reset mid-operation discards the in-flight result.
        step_model("pre_reset", 1'b1, 4'b0110, 4'b0101);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        exp_r    = '0;
        exp_f    = 4'b0000;
        exp_v    = 1'b0;
        #1 check("reset_mid_op");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset", 1'b0, '0, '0, '0, '0);

        // Exhaustive sweep of all operand pairs, one accepted every cycle.
        for (int i = 0; i < (1 << N); i++)
            for (int j = 0; j < (1 << N); j++)
                step_model($sformatf("sweep_%0d_%0d", i, j), 1'b1, N'(i), N'(j));

        // Randomized traffic with gaps in in_valid.
        for (int k = 0; k < 200; k++)
            step_model($sformatf("rand%0d", k), ($urandom_range(0, 3) != 0),
                       N'($urandom), N'($urandom));

        step("flush", 1'b0, '0, '0, '0, '0);
        @(negedge clk);
        check("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
